// File: rtl/soc_noc_responder_pkg.sv
// Shared header field positions and FSM state encoding for the NoC loopback responder.
package soc_noc_responder_pkg;

    localparam int DEST_MSB  = 31;
    localparam int DEST_LSB  = 27;
    localparam int CLASS_MSB = 26;
    localparam int CLASS_LSB = 24;
    localparam int SRC_MSB   = 23;
    localparam int SRC_LSB   = 19;
    localparam int ID_W      = DEST_MSB - DEST_LSB + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DROP = 2'd2
    } state_t;

endpackage

// File: rtl/soc_noc_responder_fifo.sv
// Pointer FIFO of {last, flit} entries; wptr can rewind to a marked packet start.
module soc_noc_responder_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W:0]    push_data,
    input  logic          pop,
    input  logic          rewind,
    input  logic [AW:0]   mark,
    output logic [W:0]    head,
    output logic [AW:0]   wptr,
    output logic [AW:0]   count
);
    import soc_noc_responder_pkg::*;

    logic [W:0]  mem [DEPTH];
    logic [AW:0] wptr_q;
    logic [AW:0] rptr_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (rewind) begin
                wptr_q <= mark;
            end else if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

    // Extra MSB makes the difference the true occupancy, full included.
    assign count = wptr_q - rptr_q;
    assign wptr  = wptr_q;
    assign head  = mem[rptr_q[AW-1:0]];

endmodule

// File: rtl/soc_noc_loopback_responder.sv
// Store-and-forward NoC far end: echoes each packet back with a reply header.
// Optional packet counters: define SOC_NOC_RESPONDER_STATS_EN.
module soc_noc_loopback_responder #(
    parameter int FLIT_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int LOCAL_ID   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLIT_WIDTH-1:0] noc_in_flit,
    input  logic                  noc_in_last,
    input  logic                  noc_in_valid,
    output logic                  noc_in_ready,
    output logic [FLIT_WIDTH-1:0] noc_out_flit,
    output logic                  noc_out_last,
    output logic                  noc_out_valid,
    input  logic                  noc_out_ready,
    output logic                  err_oversize,
    output logic [15:0]           pkt_rx_count,
    output logic [15:0]           pkt_tx_count
);
    import soc_noc_responder_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int W  = FLIT_WIDTH;

    state_t        state_q;
    state_t        state_d;
    logic [W:0]    head;
    logic [AW:0]   wptr;
    logic [AW:0]   count;
    logic [AW:0]   pkt_cnt_q;
    logic [AW:0]   pkt_cnt_d;
    logic [AW:0]   pkt_start_q;
    logic          err_q;
    logic          first_q;
    logic          drop;
    logic          in_fire;
    logic          push;
    logic          rx_last;
    logic          out_fire;
    logic          tx_last;
    logic          oversize;
    logic [W-1:0]  reply;

    assign drop     = (state_q == DROP);
    assign in_fire  = noc_in_valid && noc_in_ready;
    assign push     = in_fire && !drop;
    assign rx_last  = push && noc_in_last;
    assign out_fire = noc_out_valid && noc_out_ready;
    assign tx_last  = out_fire && head[W];

    // A full buffer with no complete packet can never drain on its own.
    assign oversize = (count == (AW+1)'(DEPTH)) && (pkt_cnt_q == '0)
                   && (state_q == IDLE);

    assign noc_in_ready = !rst && ((count < (AW+1)'(DEPTH)) || drop);

    assign pkt_cnt_d = pkt_cnt_q + (AW+1)'(rx_last) - (AW+1)'(tx_last);

    soc_noc_responder_fifo #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({noc_in_last, noc_in_flit}),
        .pop       (out_fire),
        .rewind    (oversize),
        .mark      (pkt_start_q),
        .head      (head),
        .wptr      (wptr),
        .count     (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pkt_cnt_q   <= '0;
            pkt_start_q <= '0;
            err_q       <= 1'b0;
            first_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            pkt_cnt_q <= pkt_cnt_d;
            if (rx_last) begin
                pkt_start_q <= wptr + 1'b1;
            end
            if (oversize) begin
                err_q <= 1'b1;
            end
            if (out_fire) begin
                first_q <= head[W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (oversize) begin
                    state_d = DROP;
                end else if (pkt_cnt_d != '0) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (pkt_cnt_d == '0) begin
                    state_d = IDLE;
                end
            end
            DROP: begin
                if (in_fire && noc_in_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        reply = head[W-1:0];
        reply[DEST_MSB:DEST_LSB] = head[SRC_MSB:SRC_LSB];
        reply[SRC_MSB:SRC_LSB]   = ID_W'(LOCAL_ID);
    end

    assign noc_out_valid = (state_q == SEND);
    assign noc_out_last  = noc_out_valid && head[W];
    assign noc_out_flit  = !noc_out_valid ? '0
                         : first_q ? reply : head[W-1:0];
    assign err_oversize  = err_q;

`ifdef SOC_NOC_RESPONDER_STATS_EN
    logic [15:0] rx_cnt_q;
    logic [15:0] tx_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_cnt_q <= '0;
            tx_cnt_q <= '0;
        end else begin
            if (rx_last) begin
                rx_cnt_q <= rx_cnt_q + 16'd1;
            end
            if (tx_last) begin
                tx_cnt_q <= tx_cnt_q + 16'd1;
            end
        end
    end

    assign pkt_rx_count = rx_cnt_q;
    assign pkt_tx_count = tx_cnt_q;
`else
    assign pkt_rx_count = '0;
    assign pkt_tx_count = '0;
`endif

endmodule
